// File: rtl/phy_pkg.sv
// Shared PHY lane constants: alignment/filler symbols and the lane state encoding
// used by both the transmit serializer and the receive deserializer.
package phy_pkg;

   localparam int unsigned BYTE_W = 8;

   localparam logic [BYTE_W-1:0] COMMA_SYM = 8'hBC;
   localparam logic [BYTE_W-1:0] IDLE_SYM  = 8'h7C;

   typedef enum logic {
      ST_SYNC   = 1'b0,
      ST_ACTIVE = 1'b1
   } lane_state_e;

endpackage

// File: rtl/phy_tx_serializer.sv
// Per-lane transmit serializer: byte stream in, MSB-first bit stream out at clk_8f,
// with a comma preamble after reset or on force_sync.
module phy_tx_serializer
   import phy_pkg::*;
#(
   parameter int unsigned        SYNC_COUNT = 4,
   parameter logic [BYTE_W-1:0]  COMMA      = COMMA_SYM,
   parameter logic [BYTE_W-1:0]  IDLE       = IDLE_SYM
) (
   input  logic              clk_8f,
   input  logic              reset,
   input  logic [BYTE_W-1:0] data_in,
   input  logic              valid_in,
   input  logic              force_sync,
   output logic              data_out,
   output logic              load_ack,
   output logic              byte_start,
   output logic              sync_done
);

   localparam int unsigned   CNT_W   = 3;
   localparam int unsigned   SCW     = $clog2(SYNC_COUNT + 1);
   localparam logic [SCW-1:0] SC_LAST = SCW'(SYNC_COUNT - 1);

   logic [BYTE_W-1:0] shift;
   logic [CNT_W-1:0]  bit_cnt;
   lane_state_e       state;
   logic [SCW-1:0]    sync_cnt;
   logic              sync_pend;

   logic              load_edge;
   logic              eff_pend;
   logic [BYTE_W-1:0] sel_byte;
   lane_state_e       nxt_state;
   logic [SCW-1:0]    nxt_sync_cnt;

   // Byte choice and preamble bookkeeping for the upcoming load edge.
   always_comb begin
      load_edge    = (bit_cnt == CNT_W'(7));
      eff_pend     = sync_pend | force_sync;
      nxt_state    = state;
      nxt_sync_cnt = sync_cnt;

      if ((state == ST_SYNC) || eff_pend) begin
         sel_byte = COMMA;
      end else if (valid_in) begin
         sel_byte = data_in;
      end else begin
         sel_byte = IDLE;
      end

      if (state == ST_SYNC) begin
         if (eff_pend) begin
            nxt_sync_cnt = '0;
         end else if (sync_cnt == SC_LAST) begin
            nxt_state    = ST_ACTIVE;
            nxt_sync_cnt = '0;
         end else begin
            nxt_sync_cnt = sync_cnt + SCW'(1);
         end
      end else if (eff_pend) begin
         // The comma loaded here is the first of the new preamble.
         if (SYNC_COUNT == 1) begin
            nxt_sync_cnt = '0;
         end else begin
            nxt_state    = ST_SYNC;
            nxt_sync_cnt = SCW'(1);
         end
      end
   end

   // Frame counter, shifter and lane state share one register block.
   always_ff @(posedge clk_8f or negedge reset) begin
      if (!reset) begin
         shift     <= '0;
         bit_cnt   <= CNT_W'(7);
         state     <= ST_SYNC;
         sync_cnt  <= '0;
         sync_pend <= 1'b0;
      end else if (load_edge) begin
         shift     <= sel_byte;
         bit_cnt   <= '0;
         state     <= nxt_state;
         sync_cnt  <= nxt_sync_cnt;
         sync_pend <= 1'b0;
      end else begin
         shift   <= {shift[BYTE_W-2:0], 1'b0};
         bit_cnt <= bit_cnt + CNT_W'(1);
         if (force_sync) begin
            sync_pend <= 1'b1;
         end
      end
   end

   // A same-edge force_sync pre-empts the data load, so it also withholds the ack.
   assign load_ack   = load_edge & (state == ST_ACTIVE) & ~eff_pend & valid_in;
   assign data_out   = shift[BYTE_W-1];
   assign byte_start = (bit_cnt == '0);
   assign sync_done  = (state == ST_ACTIVE);

endmodule

// File: tb/tb_phy_tx_serializer.sv
// Bench for phy_tx_serializer: frame-level directed tables plus a randomized run
// against a bit-queue reference model.
`timescale 1ns/1ps
module tb_phy_tx_serializer;
   import phy_pkg::*;

   localparam int unsigned SYNC_COUNT = 4;

   logic       clk_8f = 1'b0;
   logic       reset = 1'b0;
   logic [7:0] data_in = 8'h00;
   logic       valid_in = 1'b0;
   logic       force_sync = 1'b0;
   logic       data_out, load_ack, byte_start, sync_done;

   int checks = 0;
   int passed = 0;

   always #5 clk_8f = ~clk_8f;

   phy_tx_serializer #(.SYNC_COUNT(SYNC_COUNT)) dut (
      .clk_8f     (clk_8f),
      .reset      (reset),
      .data_in    (data_in),
      .valid_in   (valid_in),
      .force_sync (force_sync),
      .data_out   (data_out),
      .load_ack   (load_ack),
      .byte_start (byte_start),
      .sync_done  (sync_done)
   );

   // One record per serial frame: inputs held during it, byte expected on the wire.
   typedef struct {
      logic       valid;
      logic [7:0] data;
      int         force_bit;
      logic [7:0] exp_byte;
      logic       exp_ack;
      logic       exp_done;
   } frame_t;

   frame_t tbl1[23];
   frame_t tbl2[6];

   function automatic frame_t fr(input logic v, input logic [7:0] d, input int fb,
                                 input logic [7:0] eb, input logic ea, input logic ed);
      frame_t f;
      f.valid = v; f.data = d; f.force_bit = fb;
      f.exp_byte = eb; f.exp_ack = ea; f.exp_done = ed;
      return f;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   // Entered just after a load edge; leaves just after the next load edge.
   task automatic run_frame(input frame_t f, input string tag, input int idx);
      logic [7:0] got, bs, ap, dp;
      got = '0; bs = '0; ap = '0; dp = '0;
      valid_in = f.valid;
      data_in  = f.data;
      for (int k = 0; k < 8; k++) begin
         force_sync = (k == f.force_bit);
         @(negedge clk_8f);
         got = {got[6:0], data_out};
         bs  = {bs[6:0], byte_start};
         ap  = {ap[6:0], load_ack};
         dp  = {dp[6:0], sync_done};
         @(posedge clk_8f);
         #1;
      end
      force_sync = 1'b0;
      check($sformatf("%s[%0d] byte", tag, idx), 32'(got), 32'(f.exp_byte));
      check($sformatf("%s[%0d] byte_start", tag, idx), 32'(bs), 32'h80);
      check($sformatf("%s[%0d] load_ack", tag, idx), 32'(ap), 32'({7'b0, f.exp_ack}));
      check($sformatf("%s[%0d] sync_done", tag, idx), 32'(dp), 32'({8{f.exp_done}}));
   endtask

   // Reference model: a queue of the bits still to appear on data_out.
   bit  mq[$];
   bit  fq[$];
   int  commas_left;
   bit  pend;
   bit  m_bit, m_first;

   task automatic model_reset();
      mq.delete(); fq.delete();
      commas_left = SYNC_COUNT;
      pend = 0; m_bit = 0; m_first = 0;
   endtask

   task automatic model_edge(input logic v, input logic [7:0] d, input logic fs);
      logic [7:0] sym;
      bit pn;
      if (mq.size() == 0) begin
         pn = pend || fs;
         if (commas_left > 0 || pn) begin
            sym = COMMA_SYM;
            if (pn) commas_left = (commas_left > 0) ? SYNC_COUNT : SYNC_COUNT - 1;
            else    commas_left--;
         end else if (v) begin
            sym = d;
         end else begin
            sym = IDLE_SYM;
         end
         pend = 0;
         for (int i = 7; i >= 0; i--) begin
            mq.push_back(sym[i]);
            fq.push_back(i == 7);
         end
      end else if (fs) begin
         pend = 1;
      end
      m_bit   = mq.pop_front();
      m_first = fq.pop_front();
   endtask

   initial begin
      bit exp_ack, acked_last;

      tbl1[0]  = fr(0, 8'h00, -1, 8'hBC, 0, 0);
      tbl1[1]  = fr(0, 8'h00, -1, 8'hBC, 0, 0);
      tbl1[2]  = fr(0, 8'h00, -1, 8'hBC, 0, 0);
      tbl1[3]  = fr(0, 8'h00, -1, 8'hBC, 0, 1);
      tbl1[4]  = fr(0, 8'h00, -1, 8'h7C, 0, 1);
      tbl1[5]  = fr(1, 8'hA5, -1, 8'h7C, 1, 1);
      tbl1[6]  = fr(1, 8'h01, -1, 8'hA5, 1, 1);
      tbl1[7]  = fr(1, 8'hFF, -1, 8'h01, 1, 1);
      tbl1[8]  = fr(1, 8'h00, -1, 8'hFF, 1, 1);
      tbl1[9]  = fr(1, 8'h3C, -1, 8'h00, 1, 1);
      tbl1[10] = fr(1, 8'h55,  3, 8'h3C, 0, 1);
      tbl1[11] = fr(1, 8'h55, -1, 8'hBC, 0, 0);
      tbl1[12] = fr(1, 8'h55, -1, 8'hBC, 0, 0);
      tbl1[13] = fr(1, 8'h55, -1, 8'hBC, 0, 0);
      tbl1[14] = fr(1, 8'h55, -1, 8'hBC, 1, 1);
      tbl1[15] = fr(1, 8'h3C, -1, 8'h55, 1, 1);
      tbl1[16] = fr(1, 8'h55,  7, 8'h3C, 0, 1);
      tbl1[17] = fr(1, 8'h55, -1, 8'hBC, 0, 0);
      tbl1[18] = fr(1, 8'h55, -1, 8'hBC, 0, 0);
      tbl1[19] = fr(1, 8'h55, -1, 8'hBC, 0, 0);
      tbl1[20] = fr(1, 8'h55, -1, 8'hBC, 1, 1);
      tbl1[21] = fr(0, 8'h00, -1, 8'h55, 0, 1);
      tbl1[22] = fr(1, 8'hFF, -1, 8'h7C, 1, 1);

      tbl2[0] = fr(1, 8'h99, -1, 8'hBC, 0, 0);
      tbl2[1] = fr(1, 8'h99, -1, 8'hBC, 0, 0);
      tbl2[2] = fr(1, 8'h99, -1, 8'hBC, 0, 0);
      tbl2[3] = fr(1, 8'h99, -1, 8'hBC, 1, 1);
      tbl2[4] = fr(0, 8'h00, -1, 8'h99, 0, 1);
      tbl2[5] = fr(0, 8'h00, -1, 8'h7C, 0, 1);

      // Reset state
      repeat (2) @(posedge clk_8f);
      #2;
      check("rst data_out",   32'(data_out),   32'd0);
      check("rst load_ack",   32'(load_ack),   32'd0);
      check("rst byte_start", 32'(byte_start), 32'd0);
      check("rst sync_done",  32'(sync_done),  32'd0);

      // Preamble, single byte, back-to-back stream, mid-byte and load-edge force_sync
      @(negedge clk_8f);
      reset = 1'b1;
      @(posedge clk_8f);
      #1;
      for (int i = 0; i < 23; i++) run_frame(tbl1[i], "seq", i);

      // Reset mid-byte while 0xFF is shifting out; 0x99 offered across the reset
      valid_in = 1'b1;
      data_in  = 8'h99;
      #2;
      check("pre-reset data_out", 32'(data_out), 32'd1);
      reset = 1'b0;
      #1;
      check("async rst data_out",   32'(data_out),   32'd0);
      check("async rst sync_done",  32'(sync_done),  32'd0);
      check("async rst byte_start", 32'(byte_start), 32'd0);
      check("async rst load_ack",   32'(load_ack),   32'd0);
      repeat (2) @(posedge clk_8f);
      #2;
      reset = 1'b1;
      @(posedge clk_8f);
      #1;
      for (int i = 0; i < 6; i++) run_frame(tbl2[i], "rst", i);

      // Randomized run against the reference model
      reset = 1'b0;
      valid_in = 1'b0;
      force_sync = 1'b0;
      model_reset();
      repeat (2) @(posedge clk_8f);
      #3;
      reset = 1'b1;
      acked_last = 0;
      for (int c = 0; c < 2000; c++) begin
         if (!valid_in || acked_last) begin
            valid_in = ($urandom_range(0, 3) != 0);
            data_in  = 8'($urandom);
         end
         force_sync = ($urandom_range(0, 99) == 0);
         @(negedge clk_8f);
         exp_ack = (mq.size() == 0) && (commas_left == 0) && !(pend || force_sync) && valid_in;
         check($sformatf("rnd%0d data_out", c),   32'(data_out),   32'(m_bit));
         check($sformatf("rnd%0d byte_start", c), 32'(byte_start), 32'(m_first));
         check($sformatf("rnd%0d sync_done", c),  32'(sync_done),  32'(commas_left == 0));
         check($sformatf("rnd%0d load_ack", c),   32'(load_ack),   32'(exp_ack));
         @(posedge clk_8f);
         model_edge(valid_in, data_in, force_sync);
         acked_last = exp_ack;
         #1;
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
